// File: rtl/button_event_decoder.sv
// Button event decoder: turns one debounced button level into single-cycle
// short / double / long / auto-repeat events, plus a "held" level.
// Every output is registered. The state, counter and outputs are all updated
// together in a single clocked process.
module button_event_decoder #(
  parameter int unsigned CNT_W         = 26,
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES    = 15_000_000,
  parameter bit          DOUBLE_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic db_level,
  output logic short_tick,
  output logic double_tick,
  output logic long_tick,
  output logic repeat_tick,
  output logic held
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS    = 3'd1,
    LONG     = 3'd2,
    GAP      = 3'd3,
    WAIT_REL = 3'd4
  } state_t;

  // Terminal counts: the threshold is reached on the edge where cnt equals N-1.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Classify presses. Ticks default low each cycle, so every tick is one clock wide.
  // The held output is set from the state being entered, so it is in step with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      short_tick  <= 1'b0;
      double_tick <= 1'b0;
      long_tick   <= 1'b0;
      repeat_tick <= 1'b0;
      held        <= 1'b0;
    end else begin
      short_tick  <= 1'b0;
      double_tick <= 1'b0;
      long_tick   <= 1'b0;
      repeat_tick <= 1'b0;
      held        <= 1'b0;
      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (db_level) begin
              state <= PRESS;
              held  <= 1'b1;
            end
          end
          PRESS: begin
            // A release seen on the threshold edge beats the long-press threshold.
            if (!db_level) begin
              cnt <= '0;
              if (DOUBLE_EN) begin
                state <= GAP;
              end else begin
                state      <= IDLE;
                short_tick <= 1'b1;
              end
            end else if (cnt == LONG_LAST) begin
              state     <= LONG;
              long_tick <= 1'b1;
              cnt       <= '0;
              held      <= 1'b1;
            end else begin
              cnt  <= cnt + 1'b1;
              held <= 1'b1;
            end
          end
          LONG: begin
            if (!db_level) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              held <= 1'b1;
              if (cnt == REPEAT_LAST) begin
                repeat_tick <= 1'b1;
                cnt         <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          GAP: begin
            if (db_level) begin
              state       <= WAIT_REL;
              double_tick <= 1'b1;
              cnt         <= '0;
              held        <= 1'b1;
            end else if (cnt == GAP_LAST) begin
              state      <= IDLE;
              short_tick <= 1'b1;
              cnt        <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_REL: begin
            cnt <= '0;
            if (!db_level) begin
              state <= IDLE;
            end else begin
              held <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
